// File: rtl/tile_clk_rst_seq_pkg.sv
// Types shared by the tile clock/reset sequencer, its register front-end and the bench.
package tile_clk_rst_seq_pkg;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ON  = 2'd1,
      OP_OFF = 2'd2,
      OP_RST = 2'd3
   } tile_seq_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_HOLD   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } tile_seq_state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Reload value for a down-counter phase that lasts n cycles (terminal count 0).
   function automatic int unsigned phase_load(input int unsigned n);
      return (n > 1) ? n - 1 : 0;
   endfunction

endpackage

// File: rtl/tile_clk_rst_seq.sv
// Per-tile clock-enable / reset sequencer: one shared FSM runs ON, OFF (drain) and RST (drain)
// commands against a single addressed tile while every other tile's outputs hold.
module tile_clk_rst_seq
   import tile_clk_rst_seq_pkg::*;
#(
   parameter int unsigned NumTiles        = 16,
   parameter int unsigned ClkSettleCycles = 4,
   parameter int unsigned RstCycles       = 8,
   parameter int unsigned IdleTimeout     = 1024,
   localparam int unsigned IdxWidth       = (NumTiles > 1) ? $clog2(NumTiles) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  tile_seq_op_e        cmd_op_i,
   input  logic [IdxWidth-1:0] cmd_tile_i,
   output logic                rsp_valid_o,
   output logic                rsp_err_o,
   input  logic [NumTiles-1:0] tile_idle_i,
   output logic [NumTiles-1:0] tile_clk_en_o,
   output logic [NumTiles-1:0] tile_rst_no,
   output logic [NumTiles-1:0] tile_on_o
);

   localparam int unsigned CntMax   = max3(ClkSettleCycles, RstCycles, IdleTimeout);
   localparam int unsigned CntWidth = $clog2(CntMax + 1);

   typedef logic [CntWidth-1:0] cnt_t;

   localparam cnt_t SettleLoad = cnt_t'(phase_load(ClkSettleCycles));
   localparam cnt_t HoldLoad   = cnt_t'(phase_load(RstCycles));
   // The drain window is one cycle shorter than IdleTimeout so the timeout response
   // itself lands on cycle T+IdleTimeout.
   localparam cnt_t DrainLoad  = cnt_t'((IdleTimeout > 2) ? IdleTimeout - 2 : 0);

   tile_seq_state_e     state;
   tile_seq_op_e        op_q;
   cnt_t                cnt;
   logic [NumTiles-1:0] tgt_mask;

   logic                accept;
   logic                cmd_in_range;
   logic                cmd_tile_on;
   logic                tgt_idle;
   logic [NumTiles-1:0] cmd_mask;

   assign accept       = cmd_valid_i && cmd_ready_o;
   assign cmd_in_range = 32'(cmd_tile_i) < NumTiles;
   assign cmd_mask     = cmd_in_range ? (NumTiles'(1) << cmd_tile_i) : '0;
   assign cmd_tile_on  = |(tile_on_o & cmd_mask);
   assign tgt_idle     = |(tile_idle_i & tgt_mask);

   always_ff @(posedge clk_i) begin
      // NOTE: reset is sampled synchronously and wins over any sequence in flight; the
      // interrupted command is simply dropped, so no response pulse is produced for it.
      if (!rst_ni) begin
         state         <= ST_IDLE;
         op_q          <= OP_NOP;
         cnt           <= '0;
         tgt_mask      <= '0;
         cmd_ready_o   <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_err_o     <= 1'b0;
         tile_clk_en_o <= '0;
         tile_rst_no   <= '0;
         tile_on_o     <= '0;
      end else begin
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               cmd_ready_o <= 1'b1;
               if (accept) begin
                  cmd_ready_o <= 1'b0;
                  op_q        <= cmd_op_i;
                  tgt_mask    <= cmd_mask;
                  unique case (cmd_op_i)
                     OP_ON: begin
                        if (!cmd_in_range || cmd_tile_on) begin
                           state       <= ST_DONE;
                           rsp_valid_o <= 1'b1;
                           rsp_err_o   <= !cmd_in_range;
                        end else begin
                           tile_clk_en_o <= tile_clk_en_o | cmd_mask;
                           if (ClkSettleCycles > 0) begin
                              state <= ST_SETTLE;
                              cnt   <= SettleLoad;
                           end else begin
                              state <= ST_HOLD;
                              cnt   <= HoldLoad;
                           end
                        end
                     end
                     OP_OFF, OP_RST: begin
                        if (!cmd_in_range || !cmd_tile_on) begin
                           // Turning off an off tile is harmless; resetting one is an error.
                           state       <= ST_DONE;
                           rsp_valid_o <= 1'b1;
                           rsp_err_o   <= !cmd_in_range || (cmd_op_i == OP_RST);
                        end else if (IdleTimeout > 1) begin
                           state <= ST_DRAIN;
                           cnt   <= DrainLoad;
                        end else begin
                           state       <= ST_DONE;
                           rsp_valid_o <= 1'b1;
                           rsp_err_o   <= 1'b1;
                        end
                     end
                     default: begin
                        state       <= ST_DONE;
                        rsp_valid_o <= 1'b1;
                     end
                  endcase
               end
            end

            ST_SETTLE: begin
               if (cnt == '0) begin
                  state <= ST_HOLD;
                  cnt   <= HoldLoad;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_DRAIN: begin
               if (tgt_idle) begin
                  state       <= ST_HOLD;
                  cnt         <= HoldLoad;
                  tile_rst_no <= tile_rst_no & ~tgt_mask;
                  tile_on_o   <= tile_on_o & ~tgt_mask;
               end else if (cnt == '0) begin
                  state       <= ST_DONE;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_HOLD: begin
               if (cnt == '0) begin
                  state       <= ST_DONE;
                  rsp_valid_o <= 1'b1;
                  if (op_q == OP_OFF) begin
                     tile_clk_en_o <= tile_clk_en_o & ~tgt_mask;
                  end else begin
                     tile_rst_no <= tile_rst_no | tgt_mask;
                     tile_on_o   <= tile_on_o | tgt_mask;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_DONE: begin
               state       <= ST_IDLE;
               cmd_ready_o <= 1'b1;
            end

            default: begin
               state       <= ST_IDLE;
               cmd_ready_o <= 1'b0;
            end
         endcase
      end
   end

   // A tile must never leave reset while its clock is gated.
   rst_needs_clk_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (tile_rst_no & ~tile_clk_en_o) == '0);

endmodule

// File: tb/tb_tile_clk_rst_seq.sv
// Scoreboard bench for tile_clk_rst_seq: a command-level model predicts per-cycle tile outputs
// and the response, a monitor compares them against the DUT on every falling edge.
module tb_tile_clk_rst_seq;
   import tile_clk_rst_seq_pkg::*;

   localparam int unsigned N       = 5;
   localparam int unsigned SETTLE  = 4;
   localparam int unsigned HOLD    = 8;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned IW      = $clog2(N);

   logic          clk_i       = 1'b0;
   logic          rst_ni      = 1'b0;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   tile_seq_op_e  cmd_op_i    = OP_NOP;
   logic [IW-1:0] cmd_tile_i  = '0;
   logic          rsp_valid_o;
   logic          rsp_err_o;
   logic [N-1:0]  tile_idle_i = '0;
   logic [N-1:0]  tile_clk_en_o;
   logic [N-1:0]  tile_rst_no;
   logic [N-1:0]  tile_on_o;

   tile_clk_rst_seq #(
      .NumTiles        (N),
      .ClkSettleCycles (SETTLE),
      .RstCycles       (HOLD),
      .IdleTimeout     (TIMEOUT)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_op_i      (cmd_op_i),
      .cmd_tile_i    (cmd_tile_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_err_o     (rsp_err_o),
      .tile_idle_i   (tile_idle_i),
      .tile_clk_en_o (tile_clk_en_o),
      .tile_rst_no   (tile_rst_no),
      .tile_on_o     (tile_on_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int           edge_n;
      logic [N-1:0] clk;
      logic [N-1:0] rst;
      logic [N-1:0] on;
      logic         rsp;
      logic         rdy;
   } trace_t;

   typedef struct {
      int   edge_n;
      logic err;
   } rsp_t;

   trace_t       trace_q[$];
   rsp_t         rsp_q[$];
   logic [N-1:0] model_on = '0;
   int           idle_tile = -1;
   int           idle_edge = 0;
   int           n_checks = 0;
   int           n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
   endtask

   // Idle stimulus: random for every tile, except the drain target, which rises on idle_edge.
   initial forever begin
      logic [31:0] v;
      @(negedge clk_i);
      v = $urandom;
      if (idle_tile >= 0 && idle_tile < int'(N)) v[idle_tile] = (cyc + 1 >= idle_edge);
      tile_idle_i = v[N-1:0];
   end

   // Monitor: expected outputs are keyed by the clock edge after which they must be visible.
   initial forever begin
      trace_t e;
      rsp_t   r;
      @(negedge clk_i);
      if (trace_q.size() > 0 && trace_q[0].edge_n <= cyc) begin
         e = trace_q.pop_front();
         check("outputs", 32'({tile_clk_en_o, tile_rst_no, tile_on_o, rsp_valid_o, cmd_ready_o}),
               32'({e.clk, e.rst, e.on, e.rsp, e.rdy}));
      end
      if (rsp_valid_o) begin
         check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
         if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            check("rsp_edge", cyc, r.edge_n);
            check("rsp_err", 32'(rsp_err_o), 32'(r.err));
         end
      end
   end

   // Called at a falling edge; holds reset for three edges and expects all outputs low.
   task automatic do_reset();
      trace_q.delete();
      rsp_q.delete();
      rst_ni      = 1'b0;
      cmd_valid_i = 1'b0;
      for (int k = 1; k <= 3; k++) trace_q.push_back('{cyc + k, '0, '0, '0, 1'b0, 1'b0});
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      trace_q.push_back('{cyc + 1, '0, '0, '0, 1'b0, 1'b1});
      model_on = '0;
   endtask

   // Issue one command; d is the cycle (relative to acceptance) at which the target goes idle.
   task automatic issue(input tile_seq_op_e op, input int tile, input int d, input bit hold,
                        output int ta);
      int           waited = 0;
      int           lat;
      int           a;
      bit           ok;
      bit           is_on;
      bit           err;
      logic [2:0]   pre, mid, fin, t;
      logic [N-1:0] m, c, r, o;
      @(negedge clk_i);
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_tile_i  = IW'(tile);
      while (!cmd_ready_o && waited < 200) begin
         @(negedge clk_i);
         waited++;
      end
      check("ready_wait", 32'(cmd_ready_o), 32'd1);
      if (!cmd_ready_o) begin
         cmd_valid_i = 1'b0;
         ta = -1;
         return;
      end
      ta    = cyc + 1;
      ok    = tile < int'(N);
      is_on = ok ? model_on[tile] : 1'b0;
      m     = ok ? (N'(1) << tile) : '0;
      // Target bits {clk_en, rst_n, on}: pre for cycles 1..a, mid until the response, fin after.
      pre   = 3'b111;
      mid   = 3'b100;
      fin   = is_on ? 3'b111 : 3'b000;
      a     = 0;
      lat   = 1;
      err   = 1'b0;
      case (op)
         OP_ON: begin
            if (!ok) err = 1'b1;
            else if (!is_on) begin
               lat = 1 + SETTLE + HOLD;
               fin = 3'b111;
            end
         end
         OP_OFF, OP_RST: begin
            if (!ok) err = 1'b1;
            else if (!is_on) err = (op == OP_RST);
            else if (d <= int'(TIMEOUT) - 1) begin
               a   = d;
               lat = d + 1 + HOLD;
               fin = (op == OP_OFF) ? 3'b000 : 3'b111;
            end else begin
               a   = TIMEOUT;
               lat = TIMEOUT;
               err = 1'b1;
            end
         end
         default: ;
      endcase
      for (int k = 1; k <= lat + 1; k++) begin
         t = (k <= a) ? pre : (k < lat) ? mid : fin;
         c = (model_on & ~m) | (t[2] ? m : '0);
         r = (model_on & ~m) | (t[1] ? m : '0);
         o = (model_on & ~m) | (t[0] ? m : '0);
         trace_q.push_back('{ta + k - 1, c, r, o, k == lat, k == lat + 1});
      end
      rsp_q.push_back('{ta + lat - 1, err});
      model_on  = (model_on & ~m) | (fin[0] ? m : '0);
      idle_tile = tile;
      idle_edge = ta + d;
      @(posedge clk_i);
      #1;
      if (!hold) cmd_valid_i = 1'b0;
   endtask

   task automatic wait_quiet();
      int waited = 0;
      while (trace_q.size() != 0 && waited < 300) begin
         @(negedge clk_i);
         waited++;
      end
      check("sequence_complete", trace_q.size(), 0);
   endtask

   initial begin
      int ta, ta1, ta2;
      @(negedge clk_i);
      do_reset();

      issue(OP_ON, 2, 0, 1'b0, ta);          // clk_en at T+1, release + rsp at T+13
      wait_quiet();
      issue(OP_OFF, 2, 1, 1'b0, ta);         // zero-wait drain
      wait_quiet();
      issue(OP_ON, 2, 0, 1'b0, ta);
      wait_quiet();
      issue(OP_OFF, 2, 99, 1'b0, ta);        // idle never seen: timeout, tile untouched
      wait_quiet();
      issue(OP_ON, 5, 0, 1'b0, ta);          // index out of range
      issue(OP_RST, 1, 1, 1'b0, ta);         // reset of an off tile
      issue(OP_ON, 2, 0, 1'b0, ta);          // already on
      issue(OP_NOP, 3, 0, 1'b0, ta);
      issue(OP_OFF, 4, 1, 1'b0, ta);         // already off
      issue(OP_RST, 2, 3, 1'b0, ta);         // drain, hold, release
      issue(OP_OFF, 2, 15, 1'b0, ta);        // idle on the last cycle of the window
      wait_quiet();

      issue(OP_ON, 0, 0, 1'b0, ta);          // reset arrives during HOLD
      while (cyc < ta + 7) @(negedge clk_i);
      do_reset();
      wait_quiet();

      issue(OP_ON, 0, 0, 1'b1, ta1);         // valid held across both commands
      issue(OP_ON, 3, 0, 1'b0, ta2);
      check("back_to_back_gap", ta2 - ta1, 1 + SETTLE + HOLD + 1);
      wait_quiet();

      for (int i = 0; i < 40; i++) begin
         bit h;
         h = 1'(($urandom_range(0, 3) == 0));
         issue(tile_seq_op_e'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(1, 20)), h, ta);
         if (!h) repeat ($urandom_range(0, 3)) @(negedge clk_i);
      end
      cmd_valid_i = 1'b0;
      wait_quiet();
      repeat (3) @(negedge clk_i);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at edge %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
